// File: rtl/tinyqv_debug_uart_pkg.sv
// Shared constants for the tinyQV debug UART: register map, STATUS/CONFIG
// field positions and the transmitter state encoding.
package tinyqv_debug_uart_pkg;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CONFIG = 4'h8;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_LEVEL_LSB = 8;

  localparam int unsigned CFG_STOP2   = 16;
  localparam int unsigned CFG_IRQ_EN  = 17;
  localparam int unsigned CFG_THR_LSB = 20;

  localparam logic [1:0] WN_NONE = 2'b11;
  localparam logic [1:0] WN_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP1,
    S_STOP2
  } uart_state_e;

endpackage

// File: rtl/tinyqv_debug_uart_fifo_if.sv
// tinyQV peripheral bus as seen by the debug UART; the CPU side is the master.
interface tinyqv_debug_uart_fifo_if;
  logic [3:0]  addr_in;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output addr_in, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  addr_in, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tinyqv_sync_fifo.sv
// Single-clock FIFO with occupancy count; push on full and pop on empty are ignored.
module tinyqv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full check uses the pre-edge level, so a same-cycle pop never frees room for a push.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
      else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tinyqv_debug_uart_fifo.sv
// Memory-mapped debug UART transmitter: TX FIFO, runtime baud divider,
// 1/2 stop bits, sticky overflow flag and FIFO-level interrupt.
module tinyqv_debug_uart_fifo
  import tinyqv_debug_uart_pkg::*;
#(
  parameter int unsigned CLOCK_MHZ    = 64,
  parameter int unsigned DEFAULT_BAUD = 4_000_000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned DIV_WIDTH    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  tinyqv_debug_uart_fifo_if.slave  bus,
  output logic                     uart_txd,
  output logic                     tx_busy,
  output logic                     irq
);

  localparam int unsigned DEFAULT_DIV = CLOCK_MHZ * 1_000_000 / DEFAULT_BAUD - 1;
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       fifo_data;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [LVL_W-1:0] fifo_level;

  logic                 wr_any, wr_word;
  logic                 push_req;
  logic                 ovf_q, ovf_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 stop2_q, irq_en_q;
  logic [3:0]           thr_q;
  logic                 irq_q, irq_d;

  uart_state_e          state_q;
  logic [DIV_WIDTH-1:0] baud_q;
  logic [2:0]           bit_q;
  logic [7:0]           shift_q;
  logic                 txd_q;
  logic                 bit_end, frame_end, load;

  logic [31:0] status_w, config_w;

  assign wr_any   = (bus.data_write_n != WN_NONE);
  assign wr_word  = (bus.data_write_n == WN_WORD);
  assign push_req = wr_any && (bus.addr_in == ADDR_TXDATA);

  tinyqv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .data_i  (bus.data_in[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Register file: overflow set takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full)
      ovf_d = 1'b1;
    else if (wr_any && (bus.addr_in == ADDR_STATUS) && bus.data_in[ST_OVF])
      ovf_d = 1'b0;
  end

  assign irq_d = irq_en_q && (8'(fifo_level) <= 8'(thr_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q    <= 1'b0;
      div_q    <= DIV_WIDTH'(DEFAULT_DIV);
      stop2_q  <= 1'b0;
      irq_en_q <= 1'b0;
      thr_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      if (wr_word && (bus.addr_in == ADDR_CONFIG)) begin
        div_q    <= bus.data_in[DIV_WIDTH-1:0];
        stop2_q  <= bus.data_in[CFG_STOP2];
        irq_en_q <= bus.data_in[CFG_IRQ_EN];
        thr_q    <= bus.data_in[CFG_THR_LSB +: 4];
      end
    end
  end

  // Transmitter: the baud counter reloads from div_q at every bit boundary.
  assign bit_end   = (state_q != S_IDLE) && (baud_q == '0);
  assign frame_end = bit_end && ((state_q == S_STOP2) || ((state_q == S_STOP1) && !stop2_q));
  assign load      = ((state_q == S_IDLE) || frame_end) && !fifo_empty;
  assign fifo_pop  = load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else if (load) begin
      state_q <= S_START;
      shift_q <= fifo_data;
      baud_q  <= div_q;
      bit_q   <= '0;
      txd_q   <= 1'b0;
    end else if (state_q != S_IDLE) begin
      if (!bit_end) begin
        baud_q <= baud_q - 1'b1;
      end else begin
        baud_q <= div_q;
        case (state_q)
          S_START: begin
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
          S_DATA: begin
            if (bit_q == 3'd7) begin
              state_q <= S_STOP1;
              txd_q   <= 1'b1;
            end else begin
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
            end
          end
          S_STOP1: begin
            state_q <= stop2_q ? S_STOP2 : S_IDLE;
            txd_q   <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != S_IDLE) || !fifo_empty;
  assign irq      = irq_q;

  always_comb begin
    status_w                            = '0;
    status_w[ST_BUSY]                   = tx_busy;
    status_w[ST_FULL]                   = fifo_full;
    status_w[ST_EMPTY]                  = fifo_empty;
    status_w[ST_OVF]                    = ovf_q;
    status_w[ST_LEVEL_LSB +: LVL_W]     = fifo_level;
  end

  always_comb begin
    config_w                    = '0;
    config_w[DIV_WIDTH-1:0]     = div_q;
    config_w[CFG_STOP2]         = stop2_q;
    config_w[CFG_IRQ_EN]        = irq_en_q;
    config_w[CFG_THR_LSB +: 4]  = thr_q;
  end

  always_comb begin
    case (bus.addr_in)
      ADDR_TXDATA: bus.data_out = '0;
      ADDR_STATUS: bus.data_out = status_w;
      ADDR_CONFIG: bus.data_out = config_w;
      default:     bus.data_out = '1;
    endcase
  end

  assign bus.data_ready = 1'b1;

endmodule

// File: tb/tb_tinyqv_debug_uart_fifo.sv
// Directed bench for the debug UART: register map, frame timing, FIFO limits, irq, reset.
module tb_tinyqv_debug_uart_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_txd, tx_busy, irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  tinyqv_debug_uart_fifo_if bus();

  tinyqv_debug_uart_fifo #(
    .CLOCK_MHZ    (64),
    .DEFAULT_BAUD (4_000_000),
    .FIFO_DEPTH   (8),
    .DIV_WIDTH    (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [1:0] wn);
    bus.addr_in      = a;
    bus.data_in      = d;
    bus.data_write_n = wn;
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.addr_in     = a;
    bus.data_read_n = 2'b00;
    #1;
    d = bus.data_out;
    bus.data_read_n = 2'b11;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] rd;
  logic [9:0]  f55;
  logic [21:0] f2x;
  int unsigned found;

  initial begin
    bus.addr_in      = 4'h0;
    bus.data_in      = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    do_reset();

    // Reset state and register map
    bus_read(4'h4, rd); chk_eq("rst_status", rd, 32'h0000_0004);
    bus_read(4'h8, rd); chk_eq("rst_config", rd, 32'h0000_000F);
    bus_read(4'h0, rd); chk_eq("txdata_read", rd, 32'h0000_0000);
    bus_read(4'hC, rd); chk_eq("unmapped_read", rd, 32'hFFFF_FFFF);
    chk_eq("rst_txd", 32'(uart_txd), 32'd1);
    chk_eq("rst_irq", 32'(irq), 32'd0);
    chk_eq("rst_busy", 32'(tx_busy), 32'd0);

    // 0x55 at default divider 15: 10 bits x 16 cycles
    f55 = {1'b1, 8'h55, 1'b0};
    bus_write(4'h0, 32'h0000_0055, 2'b00);
    bus_read(4'h4, rd); chk_eq("push1_status", rd, 32'h0000_0101);
    @(posedge clk); #1;
    for (int c = 0; c < 160; c++) begin
      if ((c % 16 == 0) || (c % 16 == 15))
        chk_eq($sformatf("f55_c%0d", c), 32'(uart_txd), 32'(f55[c/16]));
      @(posedge clk); #1;
    end
    chk_eq("f55_idle_txd", 32'(uart_txd), 32'd1);
    chk_eq("f55_idle_busy", 32'(tx_busy), 32'd0);

    // FIFO fill: one byte goes to the shifter, 8 sit in the FIFO, the 10th overflows
    bus_write(4'h8, 32'h0000_03E8, 2'b10);
    for (int i = 0; i < 9; i++) bus_write(4'h0, 32'(i), 2'b00);
    bus_read(4'h4, rd); chk_eq("fill_status", rd, 32'h0000_0803);
    bus_write(4'h0, 32'h0000_00EE, 2'b00);
    bus_read(4'h4, rd); chk_eq("ovf_status", rd, 32'h0000_080B);
    bus_write(4'h4, 32'h0000_0008, 2'b00);
    bus_read(4'h4, rd); chk_eq("ovf_clear", rd, 32'h0000_0803);
    do_reset();

    // Divider 3 with two stop bits, two frames back-to-back
    bus_write(4'h8, 32'h0001_0003, 2'b10);
    bus_read(4'h8, rd); chk_eq("cfg_readback", rd, 32'h0001_0003);
    bus_write(4'h8, 32'h0000_0007, 2'b01);
    bus_read(4'h8, rd); chk_eq("cfg_half_ignored", rd, 32'h0001_0003);
    f2x = {2'b11, 8'h5C, 1'b0, 2'b11, 8'hA3, 1'b0};
    bus_write(4'h0, 32'h0000_00A3, 2'b00);
    bus_write(4'h0, 32'h0000_005C, 2'b00);
    for (int c = 0; c < 88; c++) begin
      if ((c % 4 == 0) || (c % 4 == 3))
        chk_eq($sformatf("f2x_c%0d", c), 32'(uart_txd), 32'(f2x[c/4]));
      @(posedge clk); #1;
    end
    chk_eq("f2x_idle_txd", 32'(uart_txd), 32'd1);
    chk_eq("f2x_idle_busy", 32'(tx_busy), 32'd0);
    do_reset();

    // irq_en, threshold 3, divider 7
    bus_write(4'h8, 32'h0032_0007, 2'b10);
    chk_eq("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk_eq("irq_empty", 32'(irq), 32'd1);
    for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h0000_0011, 2'b00);
    @(posedge clk); #1;
    chk_eq("irq_lvl4", 32'(irq), 32'd0);
    bus_read(4'h4, rd); chk_eq("irq_status4", rd, 32'h0000_0401);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(posedge clk); #1;
      bus_read(4'h4, rd);
      if (rd[15:8] == 8'd3) found = 1;
    end
    chk_eq("lvl3_reached", 32'(found), 32'd1);
    chk_eq("irq_lvl3_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk_eq("irq_lvl3", 32'(irq), 32'd1);
    do_reset();

    // Reset during a data bit of 0x00
    bus_write(4'h0, 32'h0000_0000, 2'b00);
    bus_write(4'h0, 32'h0000_005A, 2'b00);
    repeat (30) @(posedge clk);
    #1;
    chk_eq("mid_data_txd", 32'(uart_txd), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("async_rst_txd", 32'(uart_txd), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_read(4'h4, rd); chk_eq("post_rst_status", rd, 32'h0000_0004);
    bus_read(4'h8, rd); chk_eq("post_rst_config", rd, 32'h0000_000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
